pipe_stage_ctrl: RTL and testbench

Central sequencer for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage enable and flush/bubble controls from three sources: load-use hazards, taken branches resolved in EX, and a multi-cycle data-memory ready handshake.
- Contains a small FSM for memory wait with a watchdog timeout.
- Sits beside the datapath; every pipeline register's enable/flush pins are driven from here.

---
 rtl/pipe_ctrl_pkg.sv | 62 ++++++
 rtl/pipe_stage_ctrl_load_use_detect.sv | 18 +
 rtl/pipe_stage_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stage controller.
// The controller FSM encoding, the register-zero constant used by the
// load-use comparator, and the packed per-stage control bundle live here.
package pipe_ctrl_pkg;

  // Controller FSM encoding; 2'd3 is unreachable and recovers to RUN.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2,
    ST_ILLEGAL  = 2'd3
  } ctrl_state_e;

  // $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // WB control value the MEM/WB register loads while bubbled.
  localparam logic [1:0] WB_NONE = 2'b00;

  // Enable and flush pins for the PC and every pipeline register.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_bubble;
  } stage_ctrl_t;

  // Held in reset: nothing advances, every register that can is cleared.
  localparam stage_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
    id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_bubble: 1'b1};

  // Free-running pipeline.
  localparam stage_ctrl_t CTRL_NORMAL = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};

  // Data memory busy: front of the pipe holds, WB drains a bubble.
  localparam stage_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1, mem_wb_bubble: 1'b1};

  // Taken branch in EX: fetch target, squash the two younger instructions.
  localparam stage_ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};

  // Load-use: hold PC and IF/ID one cycle, inject a bubble into ID/EX.
  localparam stage_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};

  // Watchdog tripped: everything stops until reset.
  localparam stage_ctrl_t CTRL_HALT = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_bubble: 1'b1};

endpackage

// File: rtl/pipe_stage_ctrl_load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register that the
// instruction in ID reads, so ID must wait one cycle for the loaded value.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  // rs is always a source; rt only when the ID instruction actually reads it.
  assign hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage controller for the 5-stage MIPS core.
// Drives PC and pipeline-register enables/flushes from data-memory stalls,
// taken branches and load-use hazards, with a memory-wait watchdog.
// Optional macro PIPE_PERF_CNT_EN adds stall and flush performance counters.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned WAIT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        mem_wb_bubble,
  output logic [1:0]  ctrl_state,
  output logic        timeout_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  // Last wait-count value before the watchdog fires.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  stage_ctrl_t       ctrl, run_ctrl;
  logic              load_use;
  logic              run_branch;
  logic              branch_flush;
  logic              req;
  logic              err;

  load_use_detect u_load_use (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (load_use)
  );

  // Controls for a cycle with no memory freeze: branch beats load-use.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    run_ctrl   = CTRL_NORMAL;
    run_branch = 1'b0;
    if (ex_branch_taken) begin
      run_ctrl   = CTRL_BRANCH;
      run_branch = 1'b1;
    end else if (load_use) begin
      run_ctrl = CTRL_LOAD_USE;
    end
  end

  // Next-state and control decode; reset overrides the outputs combinationally.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    ctrl         = CTRL_NORMAL;
    branch_flush = 1'b0;
    req          = mem_access;
    err          = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_access && !mem_ready) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end else begin
          ctrl         = run_ctrl;
          branch_flush = run_branch;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          // Release cycle: ID/EX was held, so re-check branch and load-use now.
          ctrl         = run_ctrl;
          branch_flush = run_branch;
          state_d      = ST_RUN;
          wait_d       = '0;
        end else begin
          ctrl   = CTRL_FREEZE;
          wait_d = wait_q + WAIT_ONE;
          if (wait_q == WAIT_LAST) state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        ctrl = CTRL_HALT;
        req  = 1'b0;
        err  = 1'b1;
      end
      default: begin
        ctrl    = CTRL_HALT;
        req     = 1'b0;
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
    if (rst) begin
      ctrl         = CTRL_RESET;
      branch_flush = 1'b0;
      req          = 1'b0;
      err          = 1'b0;
    end
  end

  // FSM state and watchdog counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Count PC-hold cycles and taken-branch flushes; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.pc_en) stall_q <= stall_q + 32'd1;
      if (branch_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
  logic unused_perf;
  assign unused_perf = branch_flush;
`endif

  assign mem_req       = req;
  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_en      = ctrl.id_ex_en;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign ctrl_state    = state_q;
  assign timeout_err   = err;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed scenarios followed by
// random traffic, compared against a behavioural model of the pipeline rules.
module tb_pipe_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_access, mem_ready;
  logic        mem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, mem_wb_bubble, timeout_err;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.TIMEOUT_CYC(TO), .WAIT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .mem_wb_bubble   (mem_wb_bubble),
    .ctrl_state      (ctrl_state),
    .timeout_err     (timeout_err),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the controller: where the memory handshake stands, plus perf totals.
  bit          m_waiting;
  int          m_waited;
  bit          m_failed;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  typedef struct {
    bit       pc, ifid, ifidf, idex, idexf, exmem, memwb, bub, req, terr, flush;
    bit [1:0] st;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit hazard, freeze;
    hazard = ex_mem_read && ex_rt != 0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    freeze = mem_ready ? 1'b0 : (m_waiting || mem_access);
    e = '{pc:1, ifid:1, ifidf:0, idex:1, idexf:0, exmem:1, memwb:1, bub:0,
          req:mem_access, terr:0, flush:0, st:(m_failed ? 2'd2 : (m_waiting ? 2'd1 : 2'd0))};
    if (rst) begin
      e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwb = 0;
      e.ifidf = 1; e.idexf = 1; e.bub = 1; e.req = 0;
    end else if (m_failed) begin
      e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwb = 0;
      e.bub = 1; e.req = 0; e.terr = 1;
    end else if (freeze) begin
      e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.bub = 1;
    end else if (ex_branch_taken) begin
      e.ifidf = 1; e.idexf = 1; e.flush = 1;
    end else if (hazard) begin
      e.pc = 0; e.ifid = 0; e.idexf = 1;
    end
    return e;
  endfunction

  task automatic advance(input exp_t e);
    if (rst) begin
      m_waiting = 0; m_waited = 0; m_failed = 0; m_stalls = '0; m_flushes = '0;
    end else begin
      if (!e.pc) m_stalls = m_stalls + 32'd1;
      if (e.flush) m_flushes = m_flushes + 32'd1;
      if (!m_failed) begin
        if (m_waiting) begin
          if (mem_ready) begin
            m_waiting = 0; m_waited = 0;
          end else begin
            m_waited++;
            if (m_waited >= TO) begin m_failed = 1; m_waiting = 0; end
          end
        end else if (mem_access && !mem_ready) begin
          m_waiting = 1; m_waited = 0;
        end
      end
    end
  endtask

  // Inputs are held from the previous falling edge; check, then clock the model.
  task automatic tick(input string tag);
    exp_t e;
    #1;
    e = predict();
    check({tag, ".pc_en"},       32'(pc_en),         32'(e.pc));
    check({tag, ".if_id_en"},    32'(if_id_en),      32'(e.ifid));
    check({tag, ".if_id_flush"}, 32'(if_id_flush),   32'(e.ifidf));
    check({tag, ".id_ex_en"},    32'(id_ex_en),      32'(e.idex));
    check({tag, ".id_ex_flush"}, 32'(id_ex_flush),   32'(e.idexf));
    check({tag, ".ex_mem_en"},   32'(ex_mem_en),     32'(e.exmem));
    check({tag, ".mem_wb_en"},   32'(mem_wb_en),     32'(e.memwb));
    check({tag, ".bubble"},      32'(mem_wb_bubble), 32'(e.bub));
    check({tag, ".mem_req"},     32'(mem_req),       32'(e.req));
    check({tag, ".timeout_err"}, 32'(timeout_err),   32'(e.terr));
    check({tag, ".state"},       32'(ctrl_state),    32'(e.st));
`ifdef PIPE_PERF_CNT_EN
    check({tag, ".stalls"},      stall_cycles,       m_stalls);
    check({tag, ".flushes"},     flush_count,        m_flushes);
`else
    check({tag, ".stalls"},      stall_cycles,       32'd0);
    check({tag, ".flushes"},     flush_count,        32'd0);
`endif
    @(posedge clk);
    advance(e);
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit rd, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input bit use_rt,
                       input bit br, input bit acc, input bit rdy);
    rst = r; ex_mem_read = rd; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rt = use_rt; ex_branch_taken = br; mem_access = acc; mem_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    m_waiting = 0; m_waited = 0; m_failed = 0; m_stalls = '0; m_flushes = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick("reset0");
    tick("reset1");

    drive(0, 0, 0, 1, 2, 1, 0, 0, 0); tick("normal");
    drive(0, 1, 8, 8, 3, 0, 0, 0, 0); tick("lu_rs");
    check("lu_rs.pc_en_direct", 32'(pc_en), 32'd0);
    drive(0, 0, 8, 8, 3, 0, 0, 0, 0); tick("lu_after");
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0); tick("lu_zero");
    drive(0, 1, 9, 1, 9, 1, 0, 0, 0); tick("lu_rt");
    drive(0, 1, 9, 1, 9, 0, 0, 0, 0); tick("lu_rt_unused");
    drive(0, 1, 8, 8, 3, 0, 1, 0, 0); tick("br_lu");
    check("br_lu.pc_en_direct", 32'(pc_en), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); tick("branch2");

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick("mw0"); tick("mw1"); tick("mw2");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); tick("mw_release");
    check("mw_release.state_after", 32'(ctrl_state), 32'd0);
    tick("zero_wait");

    drive(0, 1, 8, 8, 3, 0, 0, 1, 0); tick("frz_lu0"); tick("frz_lu1");
    drive(0, 1, 8, 8, 3, 0, 0, 1, 1); tick("frz_lu_release");
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0); tick("frz_br0");
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1); tick("frz_br_release");

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) tick("timeout");
    #1 check("timeout.err_direct", 32'(timeout_err), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); tick("err_sticky");
    check("err_sticky.state_direct", 32'(ctrl_state), 32'd2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick("err_reset");

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick("rmw0"); tick("rmw1");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); tick("rmw_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("rmw_after");
    check("rmw_after.state_direct", 32'(ctrl_state), 32'd0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) < 2, $urandom_range(0, 2) != 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
